// File: rtl/udp_frame_ack_rx.sv
// Receive side of a length-prefixed frame handshake. The block captures the
// length and header, acknowledges the buffered source once downstream is
// ready, then forwards or discards the payload.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for len_hi
// LEN_LO   | waiting for len_lo
// HEAD     | shifting in HEAD_BYTES header bytes
// ACK_WAIT | header complete; in_ack pulses when out_ready (or bad length)
// PAYLOAD  | forwarding payload with one cycle of latency
// DISCARD  | consuming payload of a bad-length frame without output
module udp_frame_ack_rx #(
  parameter int          HEAD_BYTES = 12,
  parameter logic [15:0] MAX_LEN    = 16'd1600
) (
  input  logic                    tx_clk,
  input  logic                    tx_rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ack,
  input  logic                    out_ready,
  output logic [8*HEAD_BYTES-1:0] hdr,
  output logic                    hdr_valid,
  output logic [15:0]             out_len,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    err_len,
  output logic                    err_trunc,
  output logic                    err_ovr,
  output logic [15:0]             frame_cnt,
  output logic [15:0]             drop_cnt
);

  localparam int         HW      = 8 * HEAD_BYTES;
  localparam logic [15:0] HB16   = 16'(HEAD_BYTES);
  localparam logic [3:0]  HB_LAST = 4'(HEAD_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, HEAD, ACK_WAIT, PAYLOAD, DISCARD
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [3:0]    hcnt_q, hcnt_d;
  logic [HW-1:0] hdr_sr_q, hdr_sr_d;
  logic [HW-1:0] hdr_q, hdr_d;
  logic          hdr_valid_q, hdr_valid_d;
  logic [15:0]   out_len_q, out_len_d;
  logic [15:0]   tgt_q, tgt_d;
  logic [15:0]   bcnt_q, bcnt_d;
  logic          bad_q, bad_d;
  logic          in_ack_q, in_ack_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic          err_len_q, err_len_d;
  logic          err_trunc_q, err_trunc_d;
  logic          err_ovr_q, err_ovr_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          trunc_now;
  logic          len_good;
  logic [15:0]   len_rem;
  logic [15:0]   bcnt_inc;

  assign len_good = (len_q > HB16) && (len_q <= MAX_LEN);
  assign len_rem  = (len_q > HB16) ? (len_q - HB16) : 16'd0;
  assign bcnt_inc = bcnt_q + 16'd1;

  // Next-state, datapath and output pulse decisions.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hcnt_d      = hcnt_q;
    hdr_sr_d    = hdr_sr_q;
    hdr_d       = hdr_q;
    hdr_valid_d = 1'b0;
    out_len_d   = out_len_q;
    tgt_d       = tgt_q;
    bcnt_d      = bcnt_q;
    bad_d       = bad_q;
    in_ack_d    = 1'b0;
    out_data_d  = 8'd0;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    err_len_d   = 1'b0;
    err_trunc_d = 1'b0;
    err_ovr_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    trunc_now   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (in_valid) begin
          len_d   = {len_q[15:8], in_data};
          hcnt_d  = 4'd0;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (in_valid) begin
          hdr_sr_d = {hdr_sr_q[HW-9:0], in_data};
          hcnt_d   = hcnt_q + 4'd1;
          if (hcnt_q == HB_LAST) begin
            bcnt_d  = 16'd0;
            tgt_d   = len_rem;
            state_d = ACK_WAIT;
            if (len_good) begin
              bad_d = 1'b0;
              // Ack can go out immediately, so the source sees it one
              // cycle after its last header byte.
              if (out_ready) begin
                in_ack_d    = 1'b1;
                hdr_valid_d = 1'b1;
                hdr_d       = hdr_sr_d;
                out_len_d   = len_rem;
              end
            end else begin
              bad_d     = 1'b1;
              err_len_d = 1'b1;
              in_ack_d  = 1'b1;
            end
          end
        end else begin
          err_trunc_d = 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      ACK_WAIT: begin
        if (in_ack_q) begin
          state_d = bad_q ? DISCARD : PAYLOAD;
        end else begin
          if (in_valid) err_ovr_d = 1'b1;
          if (out_ready) begin
            in_ack_d    = 1'b1;
            hdr_valid_d = 1'b1;
            hdr_d       = hdr_sr_q;
            out_len_d   = tgt_q;
          end
        end
      end
      PAYLOAD: begin
        if (in_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_sop_d   = (bcnt_q == 16'd0);
          bcnt_d      = bcnt_inc;
          if (bcnt_inc == tgt_q) begin
            out_eop_d = 1'b1;
            if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
            state_d = IDLE;
          end
        end else if (bcnt_q != 16'd0) begin
          // Byte on the output right now is the last one we will get.
          trunc_now   = 1'b1;
          err_trunc_d = 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (tgt_q == 16'd0) begin
          // Nothing to discard; a byte here already belongs to the next frame.
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          if (in_valid) begin
            len_d   = {in_data, len_q[7:0]};
            state_d = LEN_LO;
          end else begin
            state_d = IDLE;
          end
        end else if (in_valid) begin
          bcnt_d = bcnt_inc;
          if (bcnt_inc == tgt_q) begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            state_d = IDLE;
          end
        end else if (bcnt_q != 16'd0) begin
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, aborting any frame.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q     <= IDLE;
      len_q       <= 16'd0;
      hcnt_q      <= 4'd0;
      hdr_sr_q    <= '0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      out_len_q   <= 16'd0;
      tgt_q       <= 16'd0;
      bcnt_q      <= 16'd0;
      bad_q       <= 1'b0;
      in_ack_q    <= 1'b0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_trunc_q <= 1'b0;
      err_ovr_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hcnt_q      <= hcnt_d;
      hdr_sr_q    <= hdr_sr_d;
      hdr_q       <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      out_len_q   <= out_len_d;
      tgt_q       <= tgt_d;
      bcnt_q      <= bcnt_d;
      bad_q       <= bad_d;
      in_ack_q    <= in_ack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      err_len_q   <= err_len_d;
      err_trunc_q <= err_trunc_d;
      err_ovr_q   <= err_ovr_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign in_ack    = in_ack_q;
  assign hdr       = hdr_q;
  assign hdr_valid = hdr_valid_q;
  assign out_len   = out_len_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q | trunc_now;
  assign err_len   = err_len_q;
  assign err_trunc = err_trunc_q;
  assign err_ovr   = err_ovr_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/udp_frame_ack_rx.md
UDP_FRAME_ACK_RX -- requirements
Module: udp_frame_ack_rx

Interface
REQ-001 Parameter HEAD_BYTES, default 12, is the number of header bytes that follow the length field.
REQ-002 Parameter MAX_LEN, default 16'd1600, is the largest accepted length-field value.
REQ-003 tx_clk  input  1  Sole clock; all logic is on the rising edge.
REQ-004 tx_rst_n  input  1  Reset; asynchronous, active-low.
REQ-005 in_data  input  8  Incoming byte stream from the buffered frame source.
REQ-006 in_valid  input  1  Qualifies in_data.
REQ-007 in_ack  output  1  One-cycle acknowledge that releases payload transfer.
REQ-008 out_ready  input  1  Downstream can accept a new frame.
REQ-009 hdr  output  8*HEAD_BYTES  Captured header; first byte in the MSBs.
REQ-010 hdr_valid  output  1  One-cycle pulse when hdr and out_len are updated.
REQ-011 out_len  output  16  Payload length, equal to L-HEAD_BYTES.
REQ-012 out_data/out_valid/out_sop/out_eop  output  8/1/1/1  Payload stream.
REQ-013 err_len/err_trunc/err_ovr  output  1 each  One-cycle error pulses.
REQ-014 frame_cnt, drop_cnt  output  16 each  Counts of good frames and dropped frames.

Function
REQ-015 Frame format on in_valid is: len_hi, len_lo, then HEAD_BYTES header bytes on consecutive valid cycles.
REQ-016 After the header, in_valid is low until the block pulses in_ack.
REQ-017 After in_ack, the payload follows: L-HEAD_BYTES bytes, contiguous, where L={len_hi,len_lo}.
REQ-018 States: IDLE, LEN_LO, HEAD, ACK_WAIT, PAYLOAD, DISCARD.
REQ-019 IDLE: a valid byte is stored as len_hi, then go to LEN_LO.
REQ-020 LEN_LO: a valid byte is stored as len_lo, the header counter is cleared, then go to HEAD.
REQ-021 LEN_LO: if in_valid is low, stay in LEN_LO.
REQ-022 HEAD: each valid byte shifts into the header register and increments the 4-bit header count.
REQ-023 HEAD: when the count reaches HEAD_BYTES, go to ACK_WAIT.
REQ-024 HEAD: if in_valid drops before the count is reached, pulse err_trunc, increment drop_cnt, and go to IDLE.
REQ-025 Length check on HEAD exit: L<=HEAD_BYTES or L>MAX_LEN is bad.
REQ-026 A bad length causes: err_len pulse, in_ack pulse on the next cycle regardless of out_ready, no hdr_valid, then DISCARD.
REQ-027 ACK_WAIT with a good length: in_ack is pulsed, registered, in the first cycle out_ready=1, together with hdr_valid and out_len=L-HEAD_BYTES; then go to PAYLOAD.
REQ-028 in_ack never asserts outside ACK_WAIT and is never high for two consecutive cycles.
REQ-029 ACK_WAIT: a valid byte arriving before in_ack is ignored, err_ovr is pulsed, and the state is unchanged.
REQ-030 PAYLOAD: out_data and out_valid equal in_data and in_valid delayed by exactly one cycle.
REQ-031 PAYLOAD: out_sop is high on the first output byte; out_eop is high on byte number out_len.
REQ-032 PAYLOAD: the 16-bit byte counter counts accepted bytes and never wraps, because L<=MAX_LEN.
REQ-033 PAYLOAD: on the last byte, increment frame_cnt (saturating at 16'hFFFF) and go to IDLE.
REQ-034 PAYLOAD: if in_valid drops before the count is reached, out_eop is forced on the last forwarded byte.
REQ-035 In the truncated case, err_trunc is pulsed, drop_cnt is incremented, and the state goes to IDLE.
REQ-036 DISCARD: L-HEAD_BYTES valid bytes are consumed without output; drop_cnt is incremented; then go to IDLE. An early in_valid drop also ends DISCARD.
REQ-037 Bytes arriving in IDLE one cycle after a frame ends start a new frame; there is no required idle gap.
REQ-038 drop_cnt saturates at 16'hFFFF.
REQ-039 Simultaneous truncation and length error are impossible; only the first detected error is reported per frame.

Reset
REQ-040 While tx_rst_n=0: state=IDLE and all counters=0.
REQ-041 While tx_rst_n=0: in_ack, hdr_valid, out_valid, out_sop, out_eop and all err_* outputs are 0.
REQ-042 While tx_rst_n=0: hdr, out_len and out_data are 0.
REQ-043 Reset assertion mid-frame aborts the frame immediately and emits no eop.
REQ-044 After tx_rst_n deasserts, the first valid byte is treated as len_hi.

Verification
REQ-045 Good frame: L=16'd20, 12 header bytes 0x01..0x0C, out_ready=1 -> in_ack 1 cycle after the last header byte; hdr_valid with out_len=8.
REQ-046 Good frame, continued: 8 payload bytes out with 1-cycle latency; sop on byte 1, eop on byte 8; frame_cnt=1.
REQ-047 Backpressure: out_ready=0 for 5 cycles in ACK_WAIT -> in_ack and hdr_valid are delayed until out_ready rises; no output before that.
REQ-048 Bad length: L=16'd10 -> err_len, in_ack still pulsed, bytes discarded, drop_cnt=1, no out_valid.
REQ-049 Truncation: L=30, in_valid drops after 5 payload bytes -> eop on byte 5, err_trunc, drop_cnt=1; the next frame is received correctly.
REQ-050 Reset mid-PAYLOAD: tx_rst_n low for 1 cycle -> all outputs are 0 immediately; the following frame L=13 yields a single byte carrying both sop and eop.
